yuv_rgb_upsampler: RTL and testbench

- Post-UART decode stage. Reads the 320x240 YUV image from external SRAM:
  - Y at full resolution.
  - U and V horizontally downsampled by 2.
- Upsamples U/V to full width with a 6-tap interpolation filter, converts every pixel to RGB, and writes packed RGB back to SRAM for the VGA unit.
- Owns the SRAM port only while the top FSM is in S_M1. Start/end are a level/pulse handshake with the top FSM.

---
 rtl/yuv_rgb_upsampler.sv | 207 ++++++++++++++++++++
 tb/tb_yuv_rgb_upsampler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/yuv_rgb_upsampler.sv
// Milestone-1 stage: reads 4:2:2 YUV from SRAM, upsamples U/V with a 6-tap filter, converts to RGB and writes packed RGB.
// Build option: define M1_CYCLE_COUNT_EN to add the m1_cycles[31:0] run-length counter port.
module yuv_rgb_upsampler #(
  parameter logic [17:0] Y_BASE   = 18'd0,
  parameter logic [17:0] U_BASE   = 18'd38400,
  parameter logic [17:0] V_BASE   = 18'd57600,
  parameter logic [17:0] RGB_BASE = 18'd146944,
  parameter int          IMG_W    = 320,
  parameter int          IMG_H    = 240
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        m1_start,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [15:0] SRAM_write_data,
`ifdef M1_CYCLE_COUNT_EN
  output logic [31:0] m1_cycles,
`endif
  output logic        m1_end
);
  localparam int          DATA_W       = 8;
  localparam logic [8:0]  LAST_K       = 9'(IMG_W / 2 - 1);
  localparam logic [7:0]  LAST_ROW     = 8'(IMG_H - 1);
  localparam logic [17:0] UV_ROW_WORDS = 18'(IMG_W / 4);

  typedef enum logic [2:0] {IDLE, ROW_INIT, PIXEL_LOOP, ROW_END, DONE} state_t;

  state_t             state_q;
  logic               armed_q;
  logic [4:0]         step_q;
  logic [8:0]         k_q;
  logic [7:0]         row_q;
  logic [17:0]        ya_q, uvrow_q, wa_q;
  logic [DATA_W-1:0]  usr_q [6];
  logic [DATA_W-1:0]  vsr_q [6];
  logic [15:0]        y_q, uw_q, vw_q;
  logic [DATA_W-1:0]  uf_q, vf_q, r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;
  logic signed [31:0] acc_q, yt_q;

  logic               pix_d, need_uv_d;
  logic [2:0]         sub_d;
  logic [17:0]        uvw_d;
  logic [8:0]         n_d;
  logic [DATA_W-1:0]  unew_d, vnew_d;
  logic signed [31:0] yv_d, uv_d, vv_d, mc_d, mx_d, base_d, sum_d;

  function automatic logic [DATA_W-1:0] clip8(input logic signed [31:0] v);
    if (v < 0) return '0;
    if (v > 32'sd255) return 8'hFF;
    return v[7:0];
  endfunction

  function automatic logic signed [31:0] pair_sum(input logic [7:0] a, input logic [7:0] b);
    return $signed({23'd0, {1'b0, a} + {1'b0, b}});
  endfunction

  // Sample k+4 enters the window after pair k; a new U/V word is fetched when k+4 is even.
  assign n_d       = k_q + 9'd4;
  assign need_uv_d = !k_q[0] && (n_d <= LAST_K);
  assign uvw_d     = uvrow_q + 18'(n_d[8:1]);
  assign unew_d    = (n_d > LAST_K) ? usr_q[5] : (n_d[0] ? uw_q[7:0] : uw_q[15:8]);
  assign vnew_d    = (n_d > LAST_K) ? vsr_q[5] : (n_d[0] ? vw_q[7:0] : vw_q[15:8]);

  // One shared multiplier, operands sequenced by step_q: filter taps in steps 6-11, CSC in 13-22.
  always_comb begin
    pix_d  = (step_q >= 5'd18);
    sub_d  = pix_d ? 3'(step_q - 5'd18) : 3'(step_q - 5'd13);
    yv_d   = $signed({24'd0, pix_d ? y_q[7:0] : y_q[15:8]}) - 32'sd16;
    uv_d   = $signed({24'd0, pix_d ? uf_q : usr_q[2]}) - 32'sd128;
    vv_d   = $signed({24'd0, pix_d ? vf_q : vsr_q[2]}) - 32'sd128;
    mc_d   = '0;
    mx_d   = '0;
    base_d = '0;
    case (step_q)
      5'd6:  begin mc_d = 32'sd21;  mx_d = pair_sum(usr_q[0], usr_q[5]); base_d = 32'sd128; end
      5'd7:  begin mc_d = -32'sd52; mx_d = pair_sum(usr_q[1], usr_q[4]); base_d = acc_q; end
      5'd8:  begin mc_d = 32'sd159; mx_d = pair_sum(usr_q[2], usr_q[3]); base_d = acc_q; end
      5'd9:  begin mc_d = 32'sd21;  mx_d = pair_sum(vsr_q[0], vsr_q[5]); base_d = 32'sd128; end
      5'd10: begin mc_d = -32'sd52; mx_d = pair_sum(vsr_q[1], vsr_q[4]); base_d = acc_q; end
      5'd11: begin mc_d = 32'sd159; mx_d = pair_sum(vsr_q[2], vsr_q[3]); base_d = acc_q; end
      default:
        if (step_q >= 5'd13 && step_q <= 5'd22) begin
          case (sub_d)
            3'd0:    begin mc_d = 32'sd76284;  mx_d = yv_d; end
            3'd1:    begin mc_d = 32'sd104595; mx_d = vv_d; base_d = yt_q; end
            3'd2:    begin mc_d = -32'sd25624; mx_d = uv_d; base_d = yt_q; end
            3'd3:    begin mc_d = -32'sd53281; mx_d = vv_d; base_d = acc_q; end
            default: begin mc_d = 32'sd132251; mx_d = uv_d; base_d = yt_q; end
          endcase
        end
    endcase
    sum_d = base_d + mc_d * mx_d;
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;  armed_q <= 1'b1;  step_q <= '0;  k_q <= '0;  row_q <= '0;
      ya_q <= '0;  uvrow_q <= '0;  wa_q <= '0;
      for (int i = 0; i < 6; i++) begin
        usr_q[i] <= '0;
        vsr_q[i] <= '0;
      end
      y_q <= '0;  uw_q <= '0;  vw_q <= '0;  uf_q <= '0;  vf_q <= '0;
      r0_q <= '0; g0_q <= '0;  b0_q <= '0;  r1_q <= '0;  g1_q <= '0;  b1_q <= '0;
      acc_q <= '0;  yt_q <= '0;
      SRAM_address <= '0;  SRAM_we_n <= 1'b1;  SRAM_write_data <= '0;  m1_end <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          SRAM_we_n <= 1'b1;
          if (m1_start && armed_q) begin
            armed_q <= 1'b0;  state_q <= ROW_INIT;  step_q <= '0;  row_q <= '0;
            ya_q <= Y_BASE;  uvrow_q <= '0;  wa_q <= RGB_BASE;
          end else if (!m1_start) begin
            armed_q <= 1'b1;
          end
        end
        // Read latency is three steps from issuing the address to capturing the word.
        ROW_INIT: begin
          step_q <= step_q + 5'd1;
          case (step_q)
            5'd0: SRAM_address <= U_BASE + uvrow_q;
            5'd1: SRAM_address <= U_BASE + uvrow_q + 18'd1;
            5'd2: SRAM_address <= V_BASE + uvrow_q;
            5'd3: begin
              SRAM_address <= V_BASE + uvrow_q + 18'd1;
              usr_q[0] <= SRAM_read_data[15:8];  usr_q[1] <= SRAM_read_data[15:8];
              usr_q[2] <= SRAM_read_data[15:8];  usr_q[3] <= SRAM_read_data[7:0];
            end
            5'd4: begin usr_q[4] <= SRAM_read_data[15:8]; usr_q[5] <= SRAM_read_data[7:0]; end
            5'd5: begin
              vsr_q[0] <= SRAM_read_data[15:8];  vsr_q[1] <= SRAM_read_data[15:8];
              vsr_q[2] <= SRAM_read_data[15:8];  vsr_q[3] <= SRAM_read_data[7:0];
            end
            default: begin
              vsr_q[4] <= SRAM_read_data[15:8];  vsr_q[5] <= SRAM_read_data[7:0];
              step_q <= '0;  k_q <= '0;  state_q <= PIXEL_LOOP;
            end
          endcase
        end
        PIXEL_LOOP: begin
          step_q <= step_q + 5'd1;
          case (step_q)
            5'd0: SRAM_address <= ya_q;
            5'd1: if (need_uv_d) SRAM_address <= U_BASE + uvw_d;
            5'd2: if (need_uv_d) SRAM_address <= V_BASE + uvw_d;
            5'd3: y_q <= SRAM_read_data;
            5'd4: if (need_uv_d) uw_q <= SRAM_read_data;
            5'd5: if (need_uv_d) vw_q <= SRAM_read_data;
            5'd6, 5'd7, 5'd8, 5'd10, 5'd11, 5'd15, 5'd20: acc_q <= sum_d;
            5'd9:  begin uf_q <= clip8(acc_q >>> 8); acc_q <= sum_d; end
            5'd12: vf_q <= clip8(acc_q >>> 8);
            5'd13, 5'd18: yt_q <= sum_d;
            5'd14: r0_q <= clip8(sum_d >>> 16);
            5'd16: g0_q <= clip8(sum_d >>> 16);
            5'd17: b0_q <= clip8(sum_d >>> 16);
            5'd19: r1_q <= clip8(sum_d >>> 16);
            5'd21: g1_q <= clip8(sum_d >>> 16);
            5'd22: b1_q <= clip8(sum_d >>> 16);
            5'd23: begin SRAM_address <= wa_q; SRAM_we_n <= 1'b0; SRAM_write_data <= {r0_q, g0_q}; wa_q <= wa_q + 18'd1; end
            5'd24: begin SRAM_address <= wa_q; SRAM_write_data <= {b0_q, r1_q}; wa_q <= wa_q + 18'd1; end
            5'd25: begin SRAM_address <= wa_q; SRAM_write_data <= {g1_q, b1_q}; wa_q <= wa_q + 18'd1; end
            default: begin
              SRAM_we_n <= 1'b1;  ya_q <= ya_q + 18'd1;  step_q <= '0;  k_q <= k_q + 9'd1;
              for (int i = 0; i < 5; i++) begin
                usr_q[i] <= usr_q[i+1];
                vsr_q[i] <= vsr_q[i+1];
              end
              usr_q[5] <= unew_d;
              vsr_q[5] <= vnew_d;
              if (k_q == LAST_K) state_q <= ROW_END;
            end
          endcase
        end
        ROW_END: begin
          row_q   <= row_q + 8'd1;
          uvrow_q <= uvrow_q + UV_ROW_WORDS;
          step_q  <= '0;
          if (row_q == LAST_ROW) begin
            state_q <= DONE;
            m1_end  <= 1'b1;
          end else begin
            state_q <= ROW_INIT;
          end
        end
        DONE: begin
          m1_end  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef M1_CYCLE_COUNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) cyc_q <= '0;
    else if (state_q == IDLE && m1_start && armed_q) cyc_q <= '0;
    else if (state_q != IDLE && state_q != DONE) cyc_q <= cyc_q + 32'd1;
  end
  assign m1_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_yuv_rgb_upsampler.sv
// Directed bench for yuv_rgb_upsampler on a reduced 16x4 image with a 2-cycle-latency SRAM model.
module tb_yuv_rgb_upsampler;
  localparam logic [17:0] YB = 18'd0;
  localparam logic [17:0] UB = 18'd38400;
  localparam logic [17:0] VB = 18'd57600;
  localparam logic [17:0] RB = 18'd146944;
  localparam int IW  = 16;
  localparam int IH  = 4;
  localparam int NW  = IW * IH * 3 / 2;
  localparam int NY  = IW * IH / 2;
  localparam int NUV = IW * IH / 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m1_start;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_write_data;
  logic        m1_end;
`ifdef M1_CYCLE_COUNT_EN
  logic [31:0] m1_cycles;
`endif

  yuv_rgb_upsampler #(
    .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .RGB_BASE(RB), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .CLOCK_50_I      (clk),
    .resetn          (resetn),
    .m1_start        (m1_start),
    .SRAM_read_data  (SRAM_read_data),
    .SRAM_address    (SRAM_address),
    .SRAM_we_n       (SRAM_we_n),
    .SRAM_write_data (SRAM_write_data),
`ifdef M1_CYCLE_COUNT_EN
    .m1_cycles       (m1_cycles),
`endif
    .m1_end          (m1_end)
  );

  always #10 clk = ~clk;

  logic [15:0] mem [0:262143];
  logic [15:0] rd_p1, rd_q;
  always @(posedge clk) begin
    rd_p1 <= mem[SRAM_address];
    rd_q  <= rd_p1;
  end
  assign SRAM_read_data = rd_q;

  int          run_id = 0;
  int          seen_run = 0;
  int          wr_cnt = 0, end_cnt = 0, mon_err = 0;
  logic        have_last = 1'b0, prev_end = 1'b0;
  logic [17:0] last_wa = '0, prev_addr = '0;
  logic [15:0] rgb [NW];
  int          rgb_tag [NW];
  logic [15:0] exp_img [NW];
  int          n_cmp = 0, n_bad = 0;

  function automatic bit in_read_seg(input logic [17:0] a);
    return ((a - YB) < 18'(NY)) || ((a - UB) < 18'(NUV)) || ((a - VB) < 18'(NUV));
  endfunction

  // Bus monitor: captures writes and flags illegal addresses, non-increasing writes, wide end pulses.
  always @(negedge clk) begin
    int e;
    e = 0;
    if (run_id != seen_run) begin
      seen_run  <= run_id;
      wr_cnt    <= 0;
      end_cnt   <= 0;
      mon_err   <= 0;
      have_last <= 1'b0;
    end else if (resetn) begin
      if (!SRAM_we_n) begin
        if ((SRAM_address - RB) >= 18'(NW)) e++;
        else begin
          rgb[int'(SRAM_address - RB)]     <= SRAM_write_data;
          rgb_tag[int'(SRAM_address - RB)] <= run_id;
        end
        if (have_last && SRAM_address <= last_wa) e++;
        last_wa   <= SRAM_address;
        have_last <= 1'b1;
        wr_cnt    <= wr_cnt + 1;
      end else if (SRAM_address != prev_addr && !in_read_seg(SRAM_address)) begin
        e++;
      end
      if (m1_end) begin
        end_cnt <= end_cnt + 1;
        if (prev_end) e++;
      end
      mon_err <= mon_err + e;
    end
    prev_addr <= SRAM_address;
    prev_end  <= m1_end;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    for (int i = 0; i < NY; i++) mem[YB + 18'(i)] = {y, y};
    for (int i = 0; i < NUV; i++) begin
      mem[UB + 18'(i)] = {u, u};
      mem[VB + 18'(i)] = {v, v};
    end
  endtask

  task automatic set_exp(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int i = 0; i < NW; i++) exp_img[i] = (i % 3 == 0) ? w0 : ((i % 3 == 1) ? w1 : w2);
  endtask

  task automatic run_image(input string tag);
    bit seen;
    m1_start = 1'b0;
    run_id++;
    repeat (3) @(negedge clk);
    m1_start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (m1_end === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " end_seen"}, {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk({tag, " end_low"}, {31'd0, m1_end}, 32'd0);
    chk({tag, " wr_cnt"}, wr_cnt, NW);
    chk({tag, " end_cnt"}, end_cnt, 32'd1);
    chk({tag, " bus_err"}, mon_err, 32'd0);
    for (int i = 0; i < NW; i++)
      chk($sformatf("%s word%0d", tag, i), {15'd0, rgb_tag[i] == run_id, rgb[i]}, {15'd0, 1'b1, exp_img[i]});
`ifdef M1_CYCLE_COUNT_EN
    begin
      logic [31:0] c1;
      c1 = m1_cycles;
      repeat (4) @(negedge clk);
      chk({tag, " cycles_nz"}, {31'd0, c1 != 32'd0}, 32'd1);
      chk({tag, " cycles_hold"}, m1_cycles, c1);
    end
`endif
  endtask

  initial begin
    resetn   = 1'b0;
    m1_start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      rgb_tag[i] = -1;
      rgb[i]     = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst addr", {14'd0, SRAM_address}, 32'd0);
    chk("rst we_n", {31'd0, SRAM_we_n}, 32'd1);
    chk("rst wdata", {16'd0, SRAM_write_data}, 32'd0);
    chk("rst m1_end", {31'd0, m1_end}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Neutral grey: all terms cancel; start stays high afterwards.
    fill(8'h10, 8'h80, 8'h80);
    set_exp(16'h0000, 16'h0000, 16'h0000);
    run_image("grey");
    repeat (150) @(negedge clk);
    chk("held wr_cnt", wr_cnt, NW);
    chk("held end_cnt", end_cnt, 32'd1);
    chk("held we_n", {31'd0, SRAM_we_n}, 32'd1);

    fill(8'hFF, 8'hFF, 8'hFF);
    set_exp(16'hFF7D, 16'hFFFF, 16'h7DFF);
    run_image("white");

    fill(8'h00, 8'h00, 8'h00);
    set_exp(16'h0087, 16'h0000, 16'h8700);
    run_image("black");

    // Single bright U[0] in row 0: left-edge clamp feeds pairs 0..2 only.
    fill(8'h10, 8'h80, 8'h80);
    mem[UB] = 16'hFF80;
    set_exp(16'h0000, 16'h0000, 16'h0000);
    exp_img[1] = 16'hFF00;
    exp_img[2] = 16'h0081;
    exp_img[5] = 16'h0500;
    exp_img[8] = 16'h0014;
    run_image("edge");

    // Abort mid-way through row 2 during a write, then a clean rerun.
    fill(8'hFF, 8'hFF, 8'hFF);
    set_exp(16'hFF7D, 16'hFFFF, 16'h7DFF);
    m1_start = 1'b0;
    run_id++;
    repeat (3) @(negedge clk);
    m1_start = 1'b1;
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 20000; c++) begin
        @(negedge clk);
        if (wr_cnt >= 60 && SRAM_we_n === 1'b0) begin
          hit = 1'b1;
          break;
        end
      end
      chk("abort reached", {31'd0, hit}, 32'd1);
    end
    chk("abort bus_err", mon_err, 32'd0);
    resetn = 1'b0;
    #1;
    chk("abort addr", {14'd0, SRAM_address}, 32'd0);
    chk("abort we_n", {31'd0, SRAM_we_n}, 32'd1);
    chk("abort wdata", {16'd0, SRAM_write_data}, 32'd0);
    chk("abort m1_end", {31'd0, m1_end}, 32'd0);
    m1_start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    run_image("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
